// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter between CPU and DMA masters
// DMA has priority; a burst limit and a one-transfer lock bound CPU deferral.
module mem_arbiter #(
   parameter int unsigned MAX_BURST = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_we,
   input  logic        cpu_byte,
   input  logic [15:0] cpu_wdata,
   output logic        cpu_ack,
   output logic [15:0] cpu_rdata,
   input  logic        dma_req,
   input  logic        dma_lock,
   input  logic [15:0] dma_addr,
   input  logic        dma_we,
   input  logic        dma_byte,
   input  logic [15:0] dma_wdata,
   output logic        dma_ack,
   output logic [15:0] dma_rdata,
   output logic [15:0] mem_addr,
   output logic        mem_we,
   output logic        mem_byte,
   output logic [15:0] mem_din,
   input  logic [15:0] mem_dout,
   output logic [1:0]  owner
);

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      CPU_XFER = 2'b01,
      DMA_XFER = 2'b10
   } state_t;

   localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       lock_flag;

   // The lock is captured at the edge that ends the locked DMA cycle and
   // steers that same arbitration, so the RMW write follows with no gap.
   assign lock_flag = (state_q == DMA_XFER) && dma_lock;

   always_comb begin
      state_d = IDLE;
      if (lock_flag && dma_req)
         state_d = DMA_XFER;
      else if (dma_req && cpu_req && (cnt_q == MAX_CNT))
         state_d = CPU_XFER;
      else if (dma_req)
         state_d = DMA_XFER;
      else if (cpu_req)
         state_d = CPU_XFER;

      cnt_d = 4'd0;
      if ((state_d == DMA_XFER) && cpu_req)
         cnt_d = (cnt_q >= MAX_CNT) ? MAX_CNT : cnt_q + 4'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Memory side is a pure mux of the owner's request so the async reset
   // of state_q kills mem_we and the acks without waiting for a clock.
   always_comb begin
      mem_addr  = 16'h0000;
      mem_we    = 1'b0;
      mem_byte  = 1'b0;
      mem_din   = 16'h0000;
      cpu_ack   = 1'b0;
      cpu_rdata = 16'h0000;
      dma_ack   = 1'b0;
      dma_rdata = 16'h0000;
      case (state_q)
         CPU_XFER: begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_byte  = cpu_byte;
            mem_din   = cpu_wdata;
            cpu_ack   = 1'b1;
            cpu_rdata = mem_dout;
         end
         DMA_XFER: begin
            mem_addr  = dma_addr;
            mem_we    = dma_we;
            mem_byte  = dma_byte;
            mem_din   = dma_wdata;
            dma_ack   = 1'b1;
            dma_rdata = mem_dout;
         end
         default: ;
      endcase
   end

   assign owner = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
// Requests and expectations are queued by the stimulus; a negedge monitor checks acks.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_byte = 1'b0;
   logic [15:0] cpu_addr = 16'h0, cpu_wdata = 16'h0;
   logic        dma_req = 1'b0, dma_lock = 1'b0, dma_we = 1'b0, dma_byte = 1'b0;
   logic [15:0] dma_addr = 16'h0, dma_wdata = 16'h0;
   logic        cpu_ack, dma_ack, mem_we, mem_byte;
   logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_din, mem_dout;
   logic [1:0]  owner;

   logic [15:0] ram [0:32767];

   mem_arbiter #(.MAX_BURST(4)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_byte(cpu_byte),
      .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_lock(dma_lock), .dma_addr(dma_addr), .dma_we(dma_we),
      .dma_byte(dma_byte), .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_byte(mem_byte), .mem_din(mem_din),
      .mem_dout(mem_dout), .owner(owner)
   );

   initial forever #5 clk = ~clk;

   // Word RAM, byte lane chosen by address bit 0, byte data from the low byte.
   assign mem_dout = ram[mem_addr[15:1]];
   always @(posedge clk) begin
      if (mem_we) begin
         if (mem_byte && mem_addr[0])
            ram[mem_addr[15:1]][15:8] <= mem_din[7:0];
         else if (mem_byte)
            ram[mem_addr[15:1]][7:0] <= mem_din[7:0];
         else
            ram[mem_addr[15:1]] <= mem_din;
      end
   end

   typedef struct packed {
      logic [15:0] addr;
      logic        we;
      logic        bm;
      logic [15:0] wdata;
      logic        lock;
   } req_t;

   typedef struct packed {
      logic [15:0] addr;
      logic        we;
      logic        bm;
      logic [15:0] din;
      logic        chk_rd;
      logic [15:0] rdata;
      logic [7:0]  lat;
   } want_t;

   req_t  cpu_rq[$], dma_rq[$];
   want_t cpu_eq[$], dma_eq[$];
   logic  grant_q[$];
   int    errors = 0, checks = 0, cyc = 0, cpu_iss = 0, dma_iss = 0;
   bit    cpu_busy = 1'b0, dma_busy = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
      end
   endtask

   task automatic issue_cpu(input logic [15:0] a, input logic we, input logic bm,
                            input logic [15:0] wd, input logic chk_rd,
                            input logic [15:0] rd, input logic [7:0] lat);
      cpu_rq.push_back('{a, we, bm, wd, 1'b0});
      cpu_eq.push_back('{a, we, bm, wd, chk_rd, rd, lat});
   endtask

   task automatic issue_dma(input logic [15:0] a, input logic we, input logic bm,
                            input logic [15:0] wd, input logic lk, input logic chk_rd,
                            input logic [15:0] rd, input logic [7:0] lat);
      dma_rq.push_back('{a, we, bm, wd, lk});
      dma_eq.push_back('{a, we, bm, wd, chk_rd, rd, lat});
   endtask

   task automatic wait_drain(input int bound);
      int n = 0;
      while ((cpu_rq.size() != 0 || dma_rq.size() != 0 || cpu_busy || dma_busy ||
              grant_q.size() != 0) && n < bound) begin
         @(posedge clk);
         n++;
      end
      if (n >= bound) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d grants still pending after %0d cycles",
                  grant_q.size(), bound);
      end
      @(negedge clk);
   endtask

   always @(posedge clk) cyc++;

   // Master drivers: load the next request just after an edge, hold until ack.
   always @(posedge clk) begin
      req_t r;
      #1;
      if (!reset) begin
         cpu_rq.delete();
         dma_rq.delete();
         cpu_busy = 1'b0;
         dma_busy = 1'b0;
         {cpu_req, cpu_addr, cpu_we, cpu_byte, cpu_wdata} = '0;
         {dma_req, dma_lock, dma_addr, dma_we, dma_byte, dma_wdata} = '0;
      end else begin
         if (!cpu_busy && cpu_rq.size() != 0) begin
            r = cpu_rq.pop_front();
            {cpu_addr, cpu_we, cpu_byte, cpu_wdata} = {r.addr, r.we, r.bm, r.wdata};
            cpu_req  = 1'b1;
            cpu_busy = 1'b1;
            cpu_iss  = cyc;
         end else if (!cpu_busy) begin
            {cpu_req, cpu_addr, cpu_we, cpu_byte, cpu_wdata} = '0;
         end
         if (!dma_busy && dma_rq.size() != 0) begin
            r = dma_rq.pop_front();
            {dma_addr, dma_we, dma_byte, dma_wdata, dma_lock} =
               {r.addr, r.we, r.bm, r.wdata, r.lock};
            dma_req  = 1'b1;
            dma_busy = 1'b1;
            dma_iss  = cyc;
         end else if (!dma_busy) begin
            {dma_req, dma_lock, dma_addr, dma_we, dma_byte, dma_wdata} = '0;
         end
      end
   end

   // Monitor: compare each ack against the queued expectation, then let the
   // acknowledged master decide whether req stays up for its next request.
   always @(negedge clk) begin
      want_t w;
      chk("ack_exclusive", {63'd0, cpu_ack & dma_ack}, 64'd0);
      if (cpu_ack) begin
         if (grant_q.size() == 0) chk("unexpected_cpu_grant", 64'd1, 64'd0);
         else chk("grant_order_cpu", 64'd0, {63'd0, grant_q.pop_front()});
         if (cpu_eq.size() == 0) chk("cpu_unexpected_ack", 64'd1, 64'd0);
         else begin
            w = cpu_eq.pop_front();
            chk("cpu_mem_addr", mem_addr, w.addr);
            chk("cpu_mem_we", mem_we, w.we);
            chk("cpu_mem_byte", mem_byte, w.bm);
            chk("cpu_mem_din", mem_din, w.din);
            if (w.chk_rd) chk("cpu_rdata", cpu_rdata, w.rdata);
            if (w.lat != 0) chk("cpu_latency", 64'(cyc - cpu_iss), 64'(w.lat));
         end
         chk("cpu_owner", owner, 2'b01);
         chk("cpu_dma_rdata_zero", dma_rdata, 16'h0);
         cpu_busy = 1'b0;
         cpu_req  = (cpu_rq.size() != 0);
      end
      if (dma_ack) begin
         if (grant_q.size() == 0) chk("unexpected_dma_grant", 64'd1, 64'd0);
         else chk("grant_order_dma", 64'd1, {63'd0, grant_q.pop_front()});
         if (dma_eq.size() == 0) chk("dma_unexpected_ack", 64'd1, 64'd0);
         else begin
            w = dma_eq.pop_front();
            chk("dma_mem_addr", mem_addr, w.addr);
            chk("dma_mem_we", mem_we, w.we);
            chk("dma_mem_byte", mem_byte, w.bm);
            chk("dma_mem_din", mem_din, w.din);
            if (w.chk_rd) chk("dma_rdata", dma_rdata, w.rdata);
            if (w.lat != 0) chk("dma_latency", 64'(cyc - dma_iss), 64'(w.lat));
         end
         chk("dma_owner", owner, 2'b10);
         chk("dma_cpu_rdata_zero", cpu_rdata, 16'h0);
         dma_busy = 1'b0;
         dma_req  = (dma_rq.size() != 0);
      end
      if (!cpu_ack && !dma_ack) begin
         chk("idle_owner", owner, 2'b00);
         chk("idle_mem", {mem_addr, mem_we, mem_byte, mem_din}, 64'd0);
         chk("idle_rdata", {cpu_rdata, dma_rdata}, 64'd0);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      bit ok;
      reset = 1'b0;
      ram[16'h0080] <= 16'h1234;
      ram[16'h0100] <= 16'h5678;
      ram[16'h0180] <= 16'h1111;
      ram[16'h0200] <= 16'h0000;
      #2;
      chk("reset_owner", owner, 2'b00);
      chk("reset_acks", {cpu_ack, dma_ack}, 2'b00);
      chk("reset_mem_we", mem_we, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Lone CPU read
      grant_q.push_back(1'b0);
      issue_cpu(16'h0100, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1234, 8'd1);
      wait_drain(20);

      // Contended burst: four DMA grants, then the CPU, repeated
      for (int i = 0; i < 10; i++) grant_q.push_back((i % 5) != 4);
      for (int i = 0; i < 2; i++) issue_cpu(16'h0100, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1234, 8'd0);
      for (int i = 0; i < 8; i++) issue_dma(16'h0200, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h5678, 8'd0);
      wait_drain(40);

      // Locked read-modify-write at the burst limit defers the CPU by one
      for (int i = 0; i < 7; i++) grant_q.push_back(i != 5);
      issue_cpu(16'h0200, 1'b0, 1'b0, 16'h0, 1'b1, 16'h9ABC, 8'd0);
      for (int i = 0; i < 3; i++) issue_dma(16'h0200, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h5678, 8'd0);
      issue_dma(16'h0200, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h5678, 8'd0);
      issue_dma(16'h0200, 1'b1, 1'b0, 16'h9ABC, 1'b0, 1'b0, 16'h0, 8'd0);
      issue_dma(16'h0100, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h1234, 8'd0);
      wait_drain(40);

      // DMA byte write into the high lane, then CPU reads the merged word
      grant_q.push_back(1'b1);
      issue_dma(16'h0301, 1'b1, 1'b1, 16'h00AB, 1'b0, 1'b0, 16'h0, 8'd1);
      wait_drain(20);
      chk("byte_write_ram", ram[16'h0180], 16'hAB11);
      grant_q.push_back(1'b0);
      issue_cpu(16'h0300, 1'b0, 1'b0, 16'h0, 1'b1, 16'hAB11, 8'd1);
      wait_drain(20);

      // Asynchronous reset in the middle of a CPU write
      cpu_rq.push_back('{16'h0400, 1'b1, 1'b0, 16'hDEAD, 1'b0});
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #2;
         if (cpu_ack) begin
            ok = 1'b1;
            break;
         end
      end
      chk("rst_pre_ack", {63'd0, ok}, 64'd1);
      chk("rst_pre_we", mem_we, 1'b1);
      reset = 1'b0;
      #1;
      chk("rst_async_we", mem_we, 1'b0);
      chk("rst_async_ack", cpu_ack, 1'b0);
      chk("rst_async_owner", owner, 2'b00);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_after_owner", owner, 2'b00);
      chk("rst_write_aborted", ram[16'h0200], 16'h0000);

      // Request drops after ack: bus returns to idle with zeroed outputs
      grant_q.push_back(1'b0);
      issue_cpu(16'h0500, 1'b1, 1'b0, 16'h4321, 1'b0, 16'h0, 8'd1);
      wait_drain(20);
      chk("drop_owner", owner, 2'b00);
      chk("drop_mem_addr", mem_addr, 16'h0);
      chk("drop_mem_din", mem_din, 16'h0);
      chk("drop_ram", ram[16'h0280], 16'h4321);

      chk("leftover_expectations", 64'(cpu_eq.size() + dma_eq.size() + grant_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
